// File: rtl/tc_irq_ctrl_pkg.sv
// tc_pkg: shared constants and types for the tc_irq_ctrl interrupt controller.
//   IFLG_ADDR / IMSK_ADDR / ICTL_ADDR : register map (8-bit addresses)
//   irq_state_e                       : request FSM state encoding
//   lowest_set()                      : priority helper, lowest set bit index
package tc_pkg;

    localparam logic [7:0] IFLG_ADDR = 8'h37;
    localparam logic [7:0] IMSK_ADDR = 8'h70;
    localparam logic [7:0] ICTL_ADDR = 8'h5F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        CLR  = 2'd2
    } irq_state_e;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tc_irq_ctrl_if.sv
// tc_irq_ctrl_if: simple register bus between a CPU-side master and the
// interrupt controller.
//   addr  : register address (ADDR_W bits)
//   wdata : write data
//   write : write strobe, one cycle per access
//   read  : read strobe, rdata valid the following cycle
//   rdata : registered read data, held between reads
interface tc_irq_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic              write;
    logic              read;
    logic [7:0]        rdata;

    modport master (output addr, output wdata, output write, output read, input rdata);
    modport slave  (input addr, input wdata, input write, input read, output rdata);
endinterface

// File: rtl/tc_irq_ctrl_sync.sv
// tc_irq_sync: per-bit source conditioning and rising-edge detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   src_i      : raw interrupt source lines
//   rise_o     : one-cycle pulse per bit on a sampled 0->1 transition
// Build option: TC_IRQ_SYNC_EN inserts a 2-flop synchroniser per bit ahead of
// the edge detector (two extra cycles of latency).
module tc_irq_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] src_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] samp_s;

`ifdef TC_IRQ_SYNC_EN
    // Arming covers both synchroniser stages plus the first history load.
    localparam int ARM_W = 3;

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage synchroniser for asynchronous source lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= src_i;
            sync_q <= meta_q;
        end
    end

    assign samp_s = sync_q;
`else
    localparam int ARM_W = 1;

    assign samp_s = src_i;
`endif

    logic [ARM_W-1:0] arm_q;
    logic [WIDTH-1:0] hist_q;

    // Edge history plus arming shift register: the history resets to 0, so
    // detection is held off until the pipeline has loaded real samples;
    // otherwise a source already high at reset release would look like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q  <= '0;
            hist_q <= '0;
        end else begin
            arm_q  <= (arm_q << 1) | ARM_W'(1'b1);
            hist_q <= samp_s;
        end
    end

    assign rise_o = samp_s & ~hist_q & {WIDTH{arm_q[ARM_W-1]}};

endmodule

// File: rtl/tc_irq_ctrl.sv
// tc_irq_ctrl: edge-triggered interrupt controller with flag/mask/control
// registers and a single prioritised CPU request.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : register bus (tc_irq_ctrl_if.slave)
//                IFLG 8'h37 W1C flags, IMSK 8'h70 mask, ICTL 8'h5F bit0 GIE
//   irq_src    : NSRC source lines, rising edge sets the matching flag
//   irq_ack    : CPU acknowledge pulse, honoured only while requesting
//   irq_out    : CPU interrupt request (registered)
//   irq_vec    : index of the requested source (registered)
// Build option: TC_IRQ_SYNC_EN adds source synchronisers (latency 4 vs 2).
module tc_irq_ctrl
    import tc_pkg::*;
#(
    parameter int NSRC   = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    tc_irq_ctrl_if.slave      bus,
    input  logic [NSRC-1:0]   irq_src,
    input  logic              irq_ack,
    output logic              irq_out,
    output logic [2:0]        irq_vec
);

    localparam logic [7:0]        SRC_MASK = 8'((9'h001 << NSRC) - 9'h001);
    localparam logic [ADDR_W-1:0] A_IFLG   = ADDR_W'(IFLG_ADDR);
    localparam logic [ADDR_W-1:0] A_IMSK   = ADDR_W'(IMSK_ADDR);
    localparam logic [ADDR_W-1:0] A_ICTL   = ADDR_W'(ICTL_ADDR);

    logic [7:0]      iflg_q, iflg_d;
    logic [7:0]      imsk_q, imsk_d;
    logic            gie_q, gie_d;
    logic [7:0]      rdata_q;
    irq_state_e      state_q;
    logic            irq_out_q;
    logic [2:0]      irq_vec_q;

    logic [NSRC-1:0] rise_s;
    logic [7:0]      set_s;
    logic [7:0]      clr_s;
    logic [7:0]      pend_s;
    logic [7:0]      rd_mux_s;
    logic            wr_iflg_s, wr_imsk_s, wr_ictl_s;
    logic            abort_s, ack_clr_s;

    tc_irq_sync #(.WIDTH(NSRC)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .src_i  (irq_src),
        .rise_o (rise_s)
    );

    assign wr_iflg_s = bus.write && (bus.addr == A_IFLG);
    assign wr_imsk_s = bus.write && (bus.addr == A_IMSK);
    assign wr_ictl_s = bus.write && (bus.addr == A_ICTL);
    assign pend_s    = iflg_q & imsk_q;

    // Request withdrawn when software disables, masks or clears it.
    assign abort_s   = !gie_q || !imsk_q[irq_vec_q] || !iflg_q[irq_vec_q];
    assign ack_clr_s = (state_q == PEND) && irq_ack && !abort_s;

    // Register next-state: set wins over clear, bits above NSRC stay zero.
    always_comb begin
        set_s             = 8'h00;
        set_s[NSRC-1:0]   = rise_s;
        clr_s  = (wr_iflg_s ? bus.wdata : 8'h00)
               | (ack_clr_s ? (8'h01 << irq_vec_q) : 8'h00);
        iflg_d = ((iflg_q & ~clr_s) | set_s) & SRC_MASK;
        imsk_d = wr_imsk_s ? (bus.wdata & SRC_MASK) : imsk_q;
        gie_d  = wr_ictl_s ? bus.wdata[0] : gie_q;
    end

    // Read data selection; unmapped addresses read zero.
    always_comb begin
        rd_mux_s = 8'h00;
        case (bus.addr)
            A_IFLG:  rd_mux_s = iflg_q;
            A_IMSK:  rd_mux_s = imsk_q;
            A_ICTL:  rd_mux_s = {7'b000_0000, gie_q};
            default: rd_mux_s = 8'h00;
        endcase
    end

    // Register file and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iflg_q  <= 8'h00;
            imsk_q  <= 8'h00;
            gie_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            iflg_q <= iflg_d;
            imsk_q <= imsk_d;
            gie_q  <= gie_d;
            if (bus.read) begin
                rdata_q <= rd_mux_s;
            end
        end
    end

    // Request FSM; irq_vec is latched on entry to PEND and frozen there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_out_q <= 1'b0;
            irq_vec_q <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gie_q && (pend_s != 8'h00)) begin
                        state_q   <= PEND;
                        irq_out_q <= 1'b1;
                        irq_vec_q <= lowest_set(pend_s);
                    end
                end
                PEND: begin
                    if (abort_s) begin
                        state_q   <= IDLE;
                        irq_out_q <= 1'b0;
                    end else if (irq_ack) begin
                        state_q   <= CLR;
                        irq_out_q <= 1'b0;
                    end
                end
                CLR: begin
                    state_q   <= IDLE;
                    irq_out_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    irq_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign irq_out   = irq_out_q;
    assign irq_vec   = irq_vec_q;

endmodule

// File: tb/tb_tc_irq_ctrl.sv
// Scoreboard bench for tc_irq_ctrl: stimulus pushes expected read data,
// request rises (vector + cycle) and request drops (cycle); an independent
// monitor pops and compares whenever the DUT presents them.
module tb_tc_irq_ctrl;
    import tc_pkg::*;

`ifdef TC_IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] irq_src = 4'h0;
    logic       irq_ack = 1'b0;
    logic       irq_out;
    logic [2:0] irq_vec;

    tc_irq_ctrl_if #(.ADDR_W(8)) bus ();

    tc_irq_ctrl #(.NSRC(4), .ADDR_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .irq_src (irq_src),
        .irq_ack (irq_ack),
        .irq_out (irq_out),
        .irq_vec (irq_vec)
    );

    always #5 clk = ~clk;

    int   cyc  = 0;
    logic rd_d = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_d <= bus.read;

    typedef struct { string name; logic [7:0] exp; } rd_t;
    typedef struct { logic [2:0] vec; int cyc; } rise_t;
    rd_t   rd_q[$];
    rise_t rise_q[$];
    int    fall_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with no expectation queued", nm);
    endtask

    // Monitor: compares at every falling edge.
    initial begin
        logic       prev_out;
        logic [2:0] cur_vec;
        logic [7:0] last_exp;
        rd_t        r;
        rise_t      e;
        int         f;
        prev_out = 1'b0;
        cur_vec  = 3'd0;
        last_exp = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_exp = 8'h00;
            end else if (rd_d) begin
                if (rd_q.size() == 0) begin
                    fail_now("rd_unexpected");
                end else begin
                    r = rd_q.pop_front();
                    check(r.name, bus.rdata, r.exp);
                    last_exp = r.exp;
                end
            end else begin
                check("rdata_hold", bus.rdata, last_exp);
            end
            if (irq_out === 1'b1 && !prev_out) begin
                if (rise_q.size() == 0) begin
                    fail_now("irq_rise_unexpected");
                end else begin
                    e = rise_q.pop_front();
                    check("rise_vec", irq_vec, e.vec);
                    check("rise_cycle", cyc, e.cyc);
                    cur_vec = e.vec;
                end
            end else if (irq_out === 1'b1) begin
                check("vec_stable", irq_vec, cur_vec);
            end else if (prev_out) begin
                if (fall_q.size() == 0) begin
                    fail_now("irq_fall_unexpected");
                end else begin
                    f = fall_q.pop_front();
                    check("fall_cycle", cyc, f);
                end
            end
            prev_out = (irq_out === 1'b1);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.write = 1'b1;
        tick(1);
        bus.write = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [7:0] a, input logic [7:0] e);
        rd_t t;
        t.name = nm;
        t.exp  = e;
        rd_q.push_back(t);
        bus.addr = a;
        bus.read = 1'b1;
        tick(1);
        bus.read = 1'b0;
    endtask

    task automatic exp_rise(input logic [2:0] v, input int c);
        rise_t t;
        t.vec = v;
        t.cyc = c;
        rise_q.push_back(t);
    endtask

    task automatic exp_fall(input int c);
        fall_q.push_back(c);
    endtask

    task automatic pulse(input int b);
        irq_src[b] = 1'b1;
        tick(2);
        irq_src[b] = 1'b0;
    endtask

    task automatic ack();
        exp_fall(cyc + 1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    initial begin
        bus.addr  = 8'h00;
        bus.wdata = 8'h00;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // Reset values, write masking of unimplemented bits, unmapped read.
        rd("rst_iflg", IFLG_ADDR, 8'h00);
        rd("rst_imsk", IMSK_ADDR, 8'h00);
        rd("rst_ictl", ICTL_ADDR, 8'h00);
        wr(IMSK_ADDR, 8'hFF);
        rd("imsk_wmask", IMSK_ADDR, 8'h0F);
        wr(ICTL_ADDR, 8'hFF);
        rd("ictl_bits", ICTL_ADDR, 8'h01);
        rd("unmapped_00", 8'h00, 8'h00);

        // Single source request, latency, acknowledge clears the flag.
        exp_rise(3'd2, cyc + LAT);
        pulse(2);
        tick(LAT + 1);
        rd("s1_iflg", IFLG_ADDR, 8'h04);
        ack();
        rd("s1_iflg_clr", IFLG_ADDR, 8'h00);
        tick(3);

        // Simultaneous edges: lowest index first, then the other after CLR.
        exp_rise(3'd1, cyc + LAT);
        irq_src[1] = 1'b1;
        irq_src[3] = 1'b1;
        tick(2);
        irq_src = 4'h0;
        tick(LAT + 1);
        exp_rise(3'd3, cyc + 3);
        ack();
        tick(4);
        ack();
        tick(3);
        rd("s2_iflg", IFLG_ADDR, 8'h00);

        // Higher-priority flag arriving while pending does not move irq_vec.
        exp_rise(3'd3, cyc + LAT);
        pulse(3);
        tick(LAT + 1);
        pulse(0);
        tick(LAT + 2);
        rd("s3_iflg", IFLG_ADDR, 8'h09);
        exp_rise(3'd0, cyc + 3);
        ack();
        tick(4);
        ack();
        tick(3);

        // Masking the pending source withdraws the request but keeps the flag.
        exp_rise(3'd1, cyc + LAT);
        pulse(1);
        tick(LAT + 1);
        exp_fall(cyc + 2);
        wr(IMSK_ADDR, 8'h00);
        tick(3);
        rd("mask_keep", IFLG_ADDR, 8'h02);
        exp_rise(3'd1, cyc + 2);
        wr(IMSK_ADDR, 8'h0F);
        tick(3);
        ack();
        tick(3);

        // GIE off: flag recorded, no request until GIE set.
        wr(ICTL_ADDR, 8'h00);
        pulse(0);
        tick(LAT + 2);
        rd("s4_iflg", IFLG_ADDR, 8'h01);
        exp_rise(3'd0, cyc + 2);
        wr(ICTL_ADDR, 8'h01);
        tick(3);
        ack();
        tick(3);

        // Software W1C of the pending flag returns to IDLE without ack.
        exp_rise(3'd2, cyc + LAT);
        pulse(2);
        tick(LAT + 1);
        exp_fall(cyc + 2);
        wr(IFLG_ADDR, 8'h04);
        tick(3);
        rd("s5_iflg", IFLG_ADDR, 8'h00);

        // Acknowledge outside PEND is ignored.
        wr(ICTL_ADDR, 8'h00);
        pulse(1);
        tick(LAT + 1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        rd("ack_idle", IFLG_ADDR, 8'h02);
        wr(IFLG_ADDR, 8'h02);
        rd("w1c_clr", IFLG_ADDR, 8'h00);

        // W1C on the same edge the source edge sets the flag: set wins.
        irq_src[0] = 1'b1;
        tick(LAT - 2);
        wr(IFLG_ADDR, 8'h01);
        irq_src[0] = 1'b0;
        rd("s6_iflg", IFLG_ADDR, 8'h01);
        rd("s6_unmapped", 8'h99, 8'h00);
        wr(IFLG_ADDR, 8'h01);
        rd("s6_clr", IFLG_ADDR, 8'h00);

        // Reset during PEND with a source held high across release.
        wr(ICTL_ADDR, 8'h01);
        exp_rise(3'd1, cyc + LAT);
        pulse(1);
        tick(LAT + 1);
        irq_src[3] = 1'b1;
        tick(LAT + 2);
        exp_fall(cyc);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(LAT + 4);
        rd("s7_iflg", IFLG_ADDR, 8'h00);
        rd("s7_imsk", IMSK_ADDR, 8'h00);
        rd("s7_ictl", ICTL_ADDR, 8'h00);
        irq_src[3] = 1'b0;
        tick(LAT + 1);
        irq_src[3] = 1'b1;
        tick(LAT + 1);
        irq_src[3] = 1'b0;
        rd("s7_new_edge", IFLG_ADDR, 8'h08);

        tick(5);
        check("rd_q_drained", rd_q.size(), 0);
        check("rise_q_drained", rise_q.size(), 0);
        check("fall_q_drained", fall_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
